// File: rtl/gpr_fwd_hazard_unit_if.sv
// Decode/write-back side signals of the GPR, forwarding and hazard unit.
// The pipeline drives through 'master'. The unit itself connects through 'slave'.
interface gpr_fwd_hazard_unit_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            id_valid;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic [AW-1:0]   id_rd;
    logic            id_rd_wen;
    logic            id_is_load;
    logic            flush;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic            stall;
    logic            wr_data_en;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd_wen, id_is_load, flush, wb_data,
        input  rs1_data, rs2_data, forward_a, forward_b, stall, wr_data_en
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd_wen, id_is_load, flush, wb_data,
        output rs1_data, rs2_data, forward_a, forward_b, stall, wr_data_en
    );
endinterface

// File: rtl/gpr_fwd_hazard_unit.sv
// 32x32 GPR file with write-through read bypass. It also contains the ID/EX, EX/MEM
// and MEM/WB destination tracker, the execute forwarding selects and the load-use stall.
module gpr_fwd_hazard_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                   risc_clk,
    input  logic                   risc_rst,
    gpr_fwd_hazard_unit_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          wen;
        logic          load;
    } idex_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          wen;
    } stage_t;

    idex_t           idex;
    idex_t           idex_next;
    stage_t          exmem;
    stage_t          memwb;
    logic [XLEN-1:0] gpr [NREGS];

    logic            wr_en;
    logic            stall_int;

    // A producer forwards only if it is live, it writes, and its destination is not x0.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic          consumer_valid,
        input stage_t        ex,
        input stage_t        wb
    );
        if (!consumer_valid)
            return 2'b00;
        if (ex.valid && ex.wen && ex.rd != '0 && ex.rd == rs)
            return 2'b10;
        if (wb.valid && wb.wen && wb.rd != '0 && wb.rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    assign wr_en = memwb.valid & memwb.wen & (memwb.rd != '0);

    assign stall_int = ~bus.flush & bus.id_valid & idex.valid & idex.load & idex.wen &
                       (idex.rd != '0) &
                       ((idex.rd == bus.id_rs1) | (idex.rd == bus.id_rs2));

    always_comb begin
        // NOTE: default every always_comb output first so that no path infers a latch.
        idex_next = '0;
        if (bus.id_valid && !bus.flush && !stall_int) begin
            idex_next.valid = 1'b1;
            idex_next.rs1   = bus.id_rs1;
            idex_next.rs2   = bus.id_rs2;
            idex_next.rd    = bus.id_rd;
            idex_next.wen   = bus.id_rd_wen;
            idex_next.load  = bus.id_is_load;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments. Each stage then samples the
    // value its upstream stage held before the edge, which is what makes the tracker shift.
    always_ff @(posedge risc_clk or posedge risc_rst) begin
        if (risc_rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex  <= idex_next;
            exmem <= '{valid: idex.valid, rd: idex.rd, wen: idex.wen};
            memwb <= exmem;
        end
    end

    // NOTE: the GPR array sits inside the async reset because architectural state must read 0
    // after reset. That rules out a reset-less RAM here.
    always_ff @(posedge risc_clk or posedge risc_rst) begin
        if (risc_rst) begin
            for (int i = 0; i < NREGS; i++)
                gpr[i] <= '0;
        end else if (wr_en) begin
            gpr[memwb.rd] <= bus.wb_data;
        end
    end

    // Same-cycle write-through keeps decode from reading a value that is one write stale.
    always_comb begin
        bus.rs1_data = gpr[bus.id_rs1];
        if (bus.id_rs1 == '0)
            bus.rs1_data = '0;
        else if (wr_en && memwb.rd == bus.id_rs1)
            bus.rs1_data = bus.wb_data;

        bus.rs2_data = gpr[bus.id_rs2];
        if (bus.id_rs2 == '0)
            bus.rs2_data = '0;
        else if (wr_en && memwb.rd == bus.id_rs2)
            bus.rs2_data = bus.wb_data;
    end

    assign bus.forward_a  = fwd_sel(idex.rs1, idex.valid, exmem, memwb);
    assign bus.forward_b  = fwd_sel(idex.rs2, idex.valid, exmem, memwb);
    assign bus.stall      = stall_int;
    assign bus.wr_data_en = wr_en;

endmodule
